// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches each word from IROM over req/ack,
// and hands it to decode with a valid/ready handshake. The next PC is formed on retire.
//
// state  | meaning
// S_RST  | out of reset, waiting one clock before the first fetch
// S_REQ  | irom_req high at pc, waiting for irom_ack
// S_HOLD | inst presented to decode, waiting for inst_ready
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        cpu_clk,
    input  logic        cpu_rst,
    input  logic [3:0]  npc_op,
    input  logic [31:0] imm,
    input  logic        br_taken,
    input  logic [31:0] alu_c,
    output logic        irom_req,
    output logic [31:0] irom_addr,
    input  logic        irom_ack,
    input  logic [31:0] irom_rdata,
    output logic [31:0] inst,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] pc,
    output logic [31:0] pc4,
    output logic        misalign
);

    // Next-PC select codes; these must match NPC_* in the core's defines.vh.
    localparam logic [3:0] NPC_PC4 = 4'd0;
    localparam logic [3:0] NPC_B   = 4'd1;
    localparam logic [3:0] NPC_JMP = 4'd2;
    localparam logic [3:0] NPC_ALU = 4'd3;

    typedef enum logic [1:0] {
        S_RST  = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [31:0] pc_q;
    logic [31:0] inst_q;
    logic        misalign_q;
    logic [31:0] pc_plus_imm;
    logic [31:0] npc;
    logic        load_inst;
    logic        retire;

    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            state <= S_RST;
        end else begin
            state <= state_nx;
        end
    end

    // Request and valid decode straight from state, so reset drops them without waiting for a clock.
    always_comb begin
        state_nx   = state;
        irom_req   = 1'b0;
        inst_valid = 1'b0;
        load_inst  = 1'b0;
        retire     = 1'b0;
        case (state)
            S_RST: begin
                state_nx = S_REQ;
            end
            S_REQ: begin
                irom_req = 1'b1;
                if (irom_ack) begin
                    load_inst = 1'b1;
                    state_nx  = S_HOLD;
                end
            end
            S_HOLD: begin
                inst_valid = 1'b1;
                if (inst_ready) begin
                    retire   = 1'b1;
                    state_nx = S_REQ;
                end
            end
            default: begin
                state_nx = S_RST;
            end
        endcase
    end

    assign pc4         = pc_q + 32'd4;
    assign pc_plus_imm = pc_q + imm;

    always_comb begin
        npc = pc4;
        case (npc_op)
            NPC_PC4: npc = pc4;
            NPC_B:   npc = br_taken ? pc_plus_imm : pc4;
            NPC_JMP: npc = pc_plus_imm;
            NPC_ALU: npc = {alu_c[31:1], 1'b0};
            default: npc = pc4;
        endcase
    end

    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            pc_q       <= RESET_PC;
            inst_q     <= 32'd0;
            misalign_q <= 1'b0;
        end else begin
            if (load_inst) begin
                inst_q <= irom_rdata;
            end
            if (retire) begin
                // Misaligned targets are forced to a word boundary; the sticky flag records it.
                pc_q <= {npc[31:2], 2'b00};
                if (npc[1:0] != 2'b00) begin
                    misalign_q <= 1'b1;
                end
            end
        end
    end

    assign irom_addr = pc_q;
    assign pc        = pc_q;
    assign inst      = inst_q;
    assign misalign  = misalign_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed plus randomized bench for if_fetch_unit; a PC/next-PC model built from the
// architectural rules predicts pc, inst and misalign after every fetch and retire.
module tb_if_fetch_unit;

    localparam logic [3:0] OP_PC4 = 4'd0;
    localparam logic [3:0] OP_B   = 4'd1;
    localparam logic [3:0] OP_JMP = 4'd2;
    localparam logic [3:0] OP_ALU = 4'd3;

    logic        cpu_clk;
    logic        cpu_rst;
    logic [3:0]  npc_op;
    logic [31:0] imm;
    logic        br_taken;
    logic [31:0] alu_c;
    logic        irom_req;
    logic [31:0] irom_addr;
    logic        irom_ack;
    logic [31:0] irom_rdata;
    logic [31:0] inst;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        misalign;

    int          n_cmp;
    int          n_fail;
    logic [31:0] exp_pc;
    logic        exp_mis;

    if_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .cpu_clk    (cpu_clk),
        .cpu_rst    (cpu_rst),
        .npc_op     (npc_op),
        .imm        (imm),
        .br_taken   (br_taken),
        .alu_c      (alu_c),
        .irom_req   (irom_req),
        .irom_addr  (irom_addr),
        .irom_ack   (irom_ack),
        .irom_rdata (irom_rdata),
        .inst       (inst),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .pc         (pc),
        .pc4        (pc4),
        .misalign   (misalign)
    );

    initial begin
        cpu_clk = 1'b0;
        forever #5 cpu_clk = ~cpu_clk;
    end

    task automatic step();
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, expv);
        end
    endtask

    // Architectural next-PC target before word alignment.
    function automatic logic [31:0] target_of(input logic [3:0] op, input logic [31:0] cur,
                                             input logic [31:0] im, input logic br,
                                             input logic [31:0] alu);
        logic [31:0] t;
        case (op)
            OP_B:    t = br ? cur + im : cur + 32'd4;
            OP_JMP:  t = cur + im;
            OP_ALU:  t = alu & 32'hFFFF_FFFE;
            default: t = cur + 32'd4;
        endcase
        return t;
    endfunction

    // One complete instruction: request (lat wait cycles), hold (stall cycles), retire.
    task automatic fetch_one(input int lat, input logic [31:0] word, input int stall,
                             input logic [3:0] op, input logic [31:0] im,
                             input logic br, input logic [31:0] alu);
        logic [31:0] t;
        chk1("req_on", irom_req, 1'b1);
        chk("req_addr", irom_addr, exp_pc);
        chk1("req_no_valid", inst_valid, 1'b0);
        chk("req_pc4", pc4, exp_pc + 32'd4);
        irom_ack = 1'b0;
        for (int i = 0; i < lat; i++) begin
            inst_ready = 1'($urandom_range(0, 1));
            step();
            chk1("req_wait", irom_req, 1'b1);
            chk("req_wait_pc", pc, exp_pc);
        end
        irom_ack   = 1'b1;
        irom_rdata = word;
        inst_ready = 1'($urandom_range(0, 1));
        step();
        irom_ack   = 1'b0;
        irom_rdata = $urandom;
        inst_ready = 1'b0;
        chk("hold_inst", inst, word);
        chk1("hold_valid", inst_valid, 1'b1);
        chk1("hold_req", irom_req, 1'b0);
        chk("hold_pc", pc, exp_pc);
        chk("hold_pc4", pc4, exp_pc + 32'd4);
        for (int i = 0; i < stall; i++) begin
            irom_ack   = 1'($urandom_range(0, 1));
            irom_rdata = $urandom;
            npc_op     = 4'($urandom_range(0, 3));
            imm        = $urandom;
            alu_c      = $urandom;
            step();
            chk("stall_inst", inst, word);
            chk("stall_pc", pc, exp_pc);
            chk1("stall_valid", inst_valid, 1'b1);
            chk1("stall_req", irom_req, 1'b0);
        end
        irom_ack   = 1'b0;
        npc_op     = op;
        imm        = im;
        br_taken   = br;
        alu_c      = alu;
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        t = target_of(op, exp_pc, im, br, alu);
        if (t[1:0] != 2'b00) exp_mis = 1'b1;
        exp_pc = t & 32'hFFFF_FFFC;
        chk("retire_pc", pc, exp_pc);
        chk1("retire_misalign", misalign, exp_mis);
        chk1("retire_valid", inst_valid, 1'b0);
    endtask

    initial begin
        n_cmp      = 0;
        n_fail     = 0;
        cpu_rst    = 1'b1;
        npc_op     = OP_PC4;
        imm        = 32'd0;
        br_taken   = 1'b0;
        alu_c      = 32'd0;
        irom_ack   = 1'b0;
        irom_rdata = 32'd0;
        inst_ready = 1'b0;
        exp_pc     = 32'd0;
        exp_mis    = 1'b0;

        #2;
        chk1("rst_req", irom_req, 1'b0);
        chk1("rst_valid", inst_valid, 1'b0);
        chk("rst_pc", pc, 32'd0);
        chk("rst_inst", inst, 32'd0);
        chk1("rst_misalign", misalign, 1'b0);
        step();
        step();
        cpu_rst = 1'b0;
        chk1("srst_no_req", irom_req, 1'b0);
        step();

        // First fetch, zero-wait IROM
        fetch_one(0, 32'h0050_0093, 0, OP_PC4, 32'd0, 1'b0, 32'd0);

        // Sequential stream with mixed ack latency
        fetch_one(3, 32'h1111_1111, 0, OP_PC4, 32'd0, 1'b0, 32'd0);
        fetch_one(0, 32'h2222_2222, 0, OP_PC4, 32'd0, 1'b0, 32'd0);
        fetch_one(3, 32'h3333_3333, 0, OP_PC4, 32'd0, 1'b0, 32'd0);

        // Branches from 0x100
        fetch_one(1, 32'h4444_4444, 0, OP_ALU, 32'd0, 1'b0, 32'h0000_0100);
        chk("b_setup", pc, 32'h0000_0100);
        fetch_one(0, 32'h5555_5555, 0, OP_B, 32'hFFFF_FFF0, 1'b1, 32'd0);
        chk("b_taken", pc, 32'h0000_00F0);
        fetch_one(0, 32'h6666_6666, 0, OP_ALU, 32'd0, 1'b0, 32'h0000_0100);
        fetch_one(2, 32'h7777_7777, 0, OP_B, 32'hFFFF_FFF0, 1'b0, 32'd0);
        chk("b_not_taken", pc, 32'h0000_0104);

        // Misaligned JALR, then a wrapping jump
        fetch_one(0, 32'h8888_8888, 0, OP_ALU, 32'd0, 1'b0, 32'h0000_0203);
        chk("alu_pc", pc, 32'h0000_0200);
        chk1("alu_misalign", misalign, 1'b1);
        fetch_one(0, 32'h9999_9999, 0, OP_ALU, 32'd0, 1'b0, 32'hFFFF_FFFC);
        fetch_one(1, 32'hAAAA_AAAA, 0, OP_JMP, 32'd8, 1'b0, 32'd0);
        chk("jmp_wrap", pc, 32'h0000_0004);

        // Long decode stall
        fetch_one(0, 32'hBBBB_BBBB, 5, OP_PC4, 32'd0, 1'b0, 32'd0);

        // Reset asserted mid-request with an ack pending, off the clock edge
        irom_ack   = 1'b1;
        irom_rdata = 32'hDEAD_BEEF;
        #2;
        cpu_rst = 1'b1;
        #1;
        chk1("midrst_req", irom_req, 1'b0);
        chk1("midrst_valid", inst_valid, 1'b0);
        chk("midrst_pc", pc, 32'd0);
        chk("midrst_inst", inst, 32'd0);
        chk1("midrst_misalign", misalign, 1'b0);
        step();
        cpu_rst = 1'b0;
        exp_pc  = 32'd0;
        exp_mis = 1'b0;
        step();
        irom_ack = 1'b0;
        chk1("restart_req", irom_req, 1'b1);
        chk("restart_addr", irom_addr, 32'd0);
        chk1("stale_ack_valid", inst_valid, 1'b0);
        chk("stale_ack_inst", inst, 32'd0);
        step();
        chk1("restart_still_req", irom_req, 1'b1);

        // Randomized traffic, including unused npc_op codes and misaligned targets
        for (int k = 0; k < 60; k++) begin
            logic [31:0] rim;
            rim = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
            fetch_one(int'($urandom_range(0, 3)), $urandom, int'($urandom_range(0, 3)),
                      4'($urandom_range(0, 6)), rim, 1'($urandom_range(0, 1)), $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
